vga_raster_ieee754: RTL and testbench

- Inverse of the float-to-pixel mapping in the VGA path: scans a W x H raster in row-major order and emits, per pixel, the IEEE-754 half-precision scene coordinates (X, Y) that map onto that pixel.
- Origin is at the screen centre, X grows right, Y grows up, scene scale is 1/SCALE per pixel.
- Feeds pipeline consumers (coverage/depth tests) over a valid/ready stream.

---
 rtl/vga_raster_ieee754_pkg.sv | 14 +
 rtl/vga_raster_ieee754_norm.sv | 75 +++++++
 rtl/vga_raster_ieee754.sv | 113 +++++++++++
 tb/tb_vga_raster_ieee754.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/vga_raster_ieee754_pkg.sv
// vga_raster_ieee754_pkg: shared constants and FSM encoding for the raster-to-half-float scanner.
//   HALF_* : half-precision field widths, bias and the +0 encoding
//   Q_W    : width of the unsigned Q8.16 magnitude fed to the normaliser
//   EXP_TOP: half exponent for a magnitude whose bit 23 is set (bias + 7 integer bits)
//   state_t: scanner FSM states
package vga_raster_ieee754_pkg;
    localparam int HALF_BIAS = 15;
    localparam int HALF_EXP_W = 5;
    localparam int HALF_MAN_W = 10;
    localparam logic [15:0] HALF_ZERO = 16'h0000;
    localparam int Q_W = 24;
    localparam int EXP_TOP = HALF_BIAS + 7;
    typedef enum logic [1:0] {S_IDLE, S_OFFSET, S_NORM, S_OUT} state_t;
endpackage

// File: rtl/vga_raster_ieee754_norm.sv
// fixed_to_half_norm: iterative Q8.16 magnitude + sign to IEEE-754 half converter.
//   i_Clock, i_Reset : clock, async active-high reset
//   i_Start          : load i_Mag/i_Sign and begin normalising
//   o_Done           : o_Half is valid (held until the next i_Start)
//   o_Half           : half-precision result
// Build option VGA_RASTER_ROUND_EN: round-to-nearest-even with one extra registered cycle;
// otherwise the mantissa is truncated and the result is combinational from the shifter.
module fixed_to_half_norm
    import vga_raster_ieee754_pkg::*;
(
    input  logic           i_Clock,
    input  logic           i_Reset,
    input  logic           i_Start,
    input  logic [Q_W-1:0] i_Mag,
    input  logic           i_Sign,
    output logic           o_Done,
    output logic [15:0]    o_Half
);
    logic [Q_W-1:0]        r_mag;
    logic [4:0]            r_k;
    logic                  r_sign;
    logic                  w_norm;
    logic                  w_zero;
    logic [HALF_EXP_W-1:0] w_exp;
    logic [15:0]           w_half;

    assign w_norm = (r_mag == '0) || r_mag[Q_W-1];
    // exponent 22 - k below 1 (k > 21) flushes to +0, as does a zero magnitude
    assign w_zero = (r_mag == '0) || (r_k > 5'(EXP_TOP - 1));
    assign w_exp  = 5'(EXP_TOP) - r_k;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_mag  <= '0;
            r_k    <= '0;
            r_sign <= 1'b0;
        end else if (i_Start) begin
            r_mag  <= i_Mag;
            r_k    <= '0;
            r_sign <= i_Sign;
        end else if (!w_norm) begin
            r_mag  <= r_mag << 1;
            r_k    <= r_k + 5'd1;
        end
    end

`ifdef VGA_RASTER_ROUND_EN
    logic [HALF_MAN_W:0] w_sum;
    logic                w_inc;
    logic                r_done;
    logic [15:0]         r_half;

    // guard = bit 12, sticky = bits 11:0, lsb = bit 13 breaks ties to even
    assign w_inc  = r_mag[12] & ((|r_mag[11:0]) | r_mag[13]);
    assign w_sum  = {1'b0, r_mag[22:13]} + 11'(w_inc);
    assign w_half = w_zero ? HALF_ZERO : {r_sign, w_exp + 5'(w_sum[HALF_MAN_W]), w_sum[HALF_MAN_W-1:0]};

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_done <= 1'b0;
            r_half <= '0;
        end else begin
            r_done <= !i_Start && w_norm;
            r_half <= w_half;
        end
    end

    assign o_Done = r_done;
    assign o_Half = r_half;
`else
    assign w_half = w_zero ? HALF_ZERO : {r_sign, w_exp, r_mag[22:13]};
    assign o_Done = w_norm;
    assign o_Half = w_half;
`endif
endmodule

// File: rtl/vga_raster_ieee754.sv
// vga_raster_ieee754: scans a W x H raster and streams the half-precision scene (X, Y) of each pixel.
//   i_Clock, i_Reset       : clock, async active-high reset
//   i_Start                : start a frame (sampled in IDLE)
//   i_Ready / o_Valid      : output stream handshake
//   o_ieee754X/Y           : half-precision scene coordinates (origin at centre, Y up)
//   o_PixelX/Y             : pixel column/row of the current output
//   o_Busy, o_FrameDone    : not idle / one-cycle end-of-frame pulse
// Build option VGA_RASTER_ROUND_EN: rounded mantissas, one extra cycle per pixel.
module vga_raster_ieee754
    import vga_raster_ieee754_pkg::*;
#(
    parameter int W     = 120,
    parameter int H     = 120,
    parameter int RECIP = 10923
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic        i_Ready,
    output logic        o_Valid,
    output logic [15:0] o_ieee754X,
    output logic [15:0] o_ieee754Y,
    output logic [16:0] o_PixelX,
    output logic [16:0] o_PixelY,
    output logic        o_Busy,
    output logic        o_FrameDone
);
    state_t         r_state, w_next;
    logic [8:0]     r_col, r_row, r_px, r_py;
    logic [15:0]    r_x, r_y;
    logic           r_valid, r_fdone;
    logic [9:0]     w_dx, w_dy, w_ax, w_ay;
    logic [Q_W-1:0] w_mx, w_my;
    logic [15:0]    w_hx, w_hy;
    logic           w_done_x, w_done_y, w_load, w_accept, w_last, w_eol;

    // signed 10-bit offsets from the centre; Y grows upward
    assign w_dx     = {1'b0, r_col} - 10'(W / 2);
    assign w_dy     = 10'(H / 2) - {1'b0, r_row};
    assign w_ax     = w_dx[9] ? -w_dx : w_dx;
    assign w_ay     = w_dy[9] ? -w_dy : w_dy;
    assign w_mx     = Q_W'(w_ax) * Q_W'(RECIP);
    assign w_my     = Q_W'(w_ay) * Q_W'(RECIP);
    assign w_load   = r_state == S_OFFSET;
    assign w_accept = r_state == S_OUT && i_Ready;
    assign w_eol    = r_col == 9'(W - 1);
    assign w_last   = w_eol && r_row == 9'(H - 1);

    fixed_to_half_norm u_norm_x (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Start(w_load),
        .i_Mag(w_mx), .i_Sign(w_dx[9]), .o_Done(w_done_x), .o_Half(w_hx)
    );

    fixed_to_half_norm u_norm_y (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Start(w_load),
        .i_Mag(w_my), .i_Sign(w_dy[9]), .o_Done(w_done_y), .o_Half(w_hy)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = i_Start ? S_OFFSET : S_IDLE;
            S_OFFSET: w_next = S_NORM;
            S_NORM:   w_next = (w_done_x && w_done_y) ? S_OUT : S_NORM;
            S_OUT:    w_next = !i_Ready ? S_OUT : (w_last ? S_IDLE : S_OFFSET);
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_col   <= '0;
            r_row   <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_fdone <= 1'b0;
        end else begin
            r_fdone <= w_accept && w_last;
            if (r_state == S_IDLE && i_Start) begin
                r_col <= '0;
                r_row <= '0;
            end
            if (r_state == S_NORM && w_done_x && w_done_y) begin
                r_valid <= 1'b1;
                r_x     <= w_hx;
                r_y     <= w_hy;
                r_px    <= r_col;
                r_py    <= r_row;
            end
            if (w_accept) begin
                r_valid <= 1'b0;
                r_col   <= w_eol ? 9'd0 : r_col + 9'd1;
                r_row   <= w_eol ? r_row + 9'd1 : r_row;
            end
        end
    end

    assign o_Valid     = r_valid;
    assign o_ieee754X  = r_x;
    assign o_ieee754Y  = r_y;
    assign o_PixelX    = {8'd0, r_px};
    assign o_PixelY    = {8'd0, r_py};
    assign o_Busy      = r_state != S_IDLE;
    assign o_FrameDone = r_fdone;
endmodule

// File: tb/tb_vga_raster_ieee754.sv
// tb_vga_raster_ieee754: scoreboard bench for vga_raster_ieee754 on a 16x16 raster (scale 1/6).
module tb_vga_raster_ieee754;
    localparam int W = 16;
    localparam int H = 16;
`ifdef VGA_RASTER_ROUND_EN
    localparam logic [15:0] X1 = 16'hBCAB, X15 = 16'h3CAB, Y15 = 16'hBCAB;
`else
    localparam logic [15:0] X1 = 16'hBCAA, X15 = 16'h3CAA, Y15 = 16'hBCAA;
`endif

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0;
    logic        o_Valid, o_Busy, o_FrameDone;
    logic [15:0] o_ieee754X, o_ieee754Y;
    logic [16:0] o_PixelX, o_PixelY;

    typedef struct {
        logic [16:0] px;
        logic [16:0] py;
        logic [15:0] x;
        logic [15:0] y;
        bit          chk;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0, n_err = 0, n_acc = 0;

    vga_raster_ieee754 #(.W(W), .H(H), .RECIP(10923)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start), .i_Ready(ready),
        .o_Valid(o_Valid), .o_ieee754X(o_ieee754X), .o_ieee754Y(o_ieee754Y),
        .o_PixelX(o_PixelX), .o_PixelY(o_PixelY), .o_Busy(o_Busy), .o_FrameDone(o_FrameDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // hand-computed halves for selected pixels; others are checked for raster order only
    task automatic push(input int c, input int r);
        exp_t e;
        e.px  = 17'(c);
        e.py  = 17'(r);
        e.chk = 1'b1;
        e.x   = 16'h0000;
        e.y   = 16'h0000;
        if (c == 0 && r == 0)        begin e.x = 16'hBD55; e.y = 16'h3D55; end
        else if (c == 1 && r == 0)   begin e.x = X1;       e.y = 16'h3D55; end
        else if (c == 2 && r == 0)   begin e.x = 16'hBC00; e.y = 16'h3D55; end
        else if (c == 8 && r == 8)   begin e.x = 16'h0000; e.y = 16'h0000; end
        else if (c == 14 && r == 2)  begin e.x = 16'h3C00; e.y = 16'h3C00; end
        else if (c == 11 && r == 8)  begin e.x = 16'h3800; e.y = 16'h0000; end
        else if (c == 15 && r == 15) begin e.x = X15;      e.y = Y15;      end
        else e.chk = 1'b0;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && o_Valid && ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got pixel (%0d,%0d) expected none", o_PixelX, o_PixelY);
            end else begin
                m_e = q.pop_front();
                chk("pixel_x", 32'(o_PixelX), 32'(m_e.px));
                chk("pixel_y", 32'(o_PixelY), 32'(m_e.py));
                if (m_e.chk) begin
                    chk("half_x", 32'(o_ieee754X), 32'(m_e.x));
                    chk("half_y", 32'(o_ieee754Y), 32'(m_e.y));
                end
                n_acc++;
            end
        end
    end

    initial begin
        int t;
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_Valid), 0);
        chk("rst_busy", 32'(o_Busy), 0);
        chk("rst_done", 32'(o_FrameDone), 0);
        chk("rst_x", 32'(o_ieee754X), 0);
        chk("rst_y", 32'(o_ieee754Y), 0);
        chk("rst_px", 32'(o_PixelX), 0);
        chk("rst_py", 32'(o_PixelY), 0);
        rst = 1'b0;

        push(0, 0);
        push(1, 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t = 0;
        while (!o_Valid && t < 50) begin @(posedge clk); #1; t++; end
        chk("first_valid", 32'(o_Valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(o_Valid), 1);
            chk("hold_x", 32'(o_ieee754X), 32'hBD55);
            chk("hold_y", 32'(o_ieee754Y), 32'h3D55);
            chk("hold_px", 32'(o_PixelX), 0);
        end
        ready = 1'b1;
        t = 0;
        while (q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
        chk("drain_ab", 32'(q.size()), 0);

        // pixel (2,0) is now in OFFSET; reset lands mid-NORM
        ready = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_Valid), 0);
        chk("arst_busy", 32'(o_Busy), 0);
        chk("arst_px", 32'(o_PixelX), 0);
        chk("arst_x", 32'(o_ieee754X), 0);
        @(posedge clk); #1 rst = 1'b0;
        q.delete();

        base = n_acc;
        ready = 1'b1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                push(c, r);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t = 0;
        while (!o_FrameDone && t < 20000) begin
            @(posedge clk); #1;
            start = (t == 300);
            t++;
        end
        start = 1'b0;
        chk("frame_done", 32'(o_FrameDone), 1);
        chk("frame_busy", 32'(o_Busy), 0);
        chk("frame_valid", 32'(o_Valid), 0);
        chk("frame_count", 32'(n_acc - base), W * H);
        chk("frame_queue", 32'(q.size()), 0);
        @(posedge clk); #1;
        chk("done_pulse", 32'(o_FrameDone), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
